// File: rtl/ucode_sequencer.sv
// Microcode sequencer: walks the ghost PC through the ucode ROM for trapped multiply opcodes.
// Optional runaway guard (loop count / ghost PC wrap) enabled by defining UCODE_LOOP_GUARD_EN.
module ucode_sequencer #(
    parameter int unsigned UPC_W    = 5,
    parameter logic [15:0] LOOP_MAX = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_valid,
    input  logic [6:0]       trap_opcode,
    input  logic [3:0]       trap_rd,
    input  logic [3:0]       trap_rs,
    input  logic [15:0]      trap_imm,
    output logic             fetch_stall,
    output logic             ucode_active,
    output logic [UPC_W-1:0] ghost_pc,
    input  logic [31:0]      rom_instr,
    output logic             ghost_valid,
    output logic [31:0]      ghost_instr,
    input  logic             ghost_ready,
    input  logic             zflag_valid,
    input  logic             zflag,
    output logic             ucode_done,
    output logic             seq_error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAITZ} state_t;

    localparam logic [6:0] CLS_ULOOP = 7'b1110001;
    localparam logic [6:0] CLS_UEND  = 7'b1111111;

    state_t           state, state_d;
    logic [UPC_W-1:0] pc_q, pc_d;
    logic [3:0]       rd_q, rs_q;
    logic [15:0]      imm_q;
    logic             entry_hit;
    logic [UPC_W-1:0] entry_pc;
    logic             is_loop, is_end, is_fwd;
    logic             latch_ops;
    logic             abort;
`ifdef UCODE_LOOP_GUARD_EN
    logic [15:0]      cnt_q, cnt_d;
    logic             err_q, err_set;
`endif

    assign is_loop = (rom_instr[31:25] == CLS_ULOOP);
    assign is_end  = (rom_instr[31:25] == CLS_UEND);
    assign is_fwd  = !is_loop && !is_end;

    always_comb begin
        entry_hit = 1'b1;
        entry_pc  = '0;
        case (trap_opcode)
            7'b0010000: entry_pc = UPC_W'(0);
            7'b0011000: entry_pc = UPC_W'(8);
            7'b0110000: entry_pc = UPC_W'(16);
            7'b0111000: entry_pc = UPC_W'(24);
            default:    entry_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc_q  <= '0;
            rd_q  <= '0;
            rs_q  <= '0;
            imm_q <= '0;
`ifdef UCODE_LOOP_GUARD_EN
            cnt_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            pc_q  <= pc_d;
            if (latch_ops) begin
                rd_q  <= trap_rd;
                rs_q  <= trap_rs;
                imm_q <= trap_imm;
            end
`ifdef UCODE_LOOP_GUARD_EN
            cnt_q <= cnt_d;
            if (err_set) err_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc_q;
        latch_ops = 1'b0;
        abort     = 1'b0;
`ifdef UCODE_LOOP_GUARD_EN
        cnt_d     = cnt_q;
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (trap_valid && entry_hit) begin
                    state_d   = ISSUE;
                    pc_d      = entry_pc;
                    latch_ops = 1'b1;
`ifdef UCODE_LOOP_GUARD_EN
                    cnt_d     = '0;
`endif
                end
            end
            ISSUE: begin
                if (is_end) begin
                    state_d = IDLE;
                end else if (is_loop) begin
                    state_d = WAITZ;
                end else if (ghost_ready) begin
                    pc_d = pc_q + UPC_W'(1);
`ifdef UCODE_LOOP_GUARD_EN
                    if (pc_q == '1) begin
                        err_set = 1'b1;
                        abort   = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
            WAITZ: begin
                if (zflag_valid) begin
                    state_d = ISSUE;
                    if (zflag) begin
                        pc_d = pc_q + UPC_W'(1);
                    end else begin
`ifdef UCODE_LOOP_GUARD_EN
                        // A taken branch at the limit ends the routine instead of looping.
                        if (cnt_q == LOOP_MAX) begin
                            err_set = 1'b1;
                            abort   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            pc_d  = rom_instr[UPC_W-1:0];
                            cnt_d = cnt_q + 16'd1;
                        end
`else
                        pc_d = rom_instr[UPC_W-1:0];
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ucode_active = (state != IDLE);
        fetch_stall  = (state != IDLE) || (trap_valid && entry_hit);
        ghost_pc     = pc_q;
        ghost_valid  = (state == ISSUE) && is_fwd;
        ucode_done   = ((state == ISSUE) && is_end) || abort;
        ghost_instr  = rom_instr;
        if (rom_instr[24:21] == 4'hF)     ghost_instr[24:21] = rd_q;
        if (rom_instr[20:17] == 4'hE)     ghost_instr[20:17] = rs_q;
        if (rom_instr[15:0]  == 16'hFFFF) ghost_instr[15:0]  = imm_q;
`ifdef UCODE_LOOP_GUARD_EN
        seq_error    = err_q;
`else
        seq_error    = 1'b0;
`endif
    end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Microcode sequencer for trapped multiply opcodes.
- On a trap from fetch, it stalls the architectural PC and walks the ghost PC through the microcode ROM. Ghost instructions go to decode with operand substitution.
- It resolves loop-back micro-branches using the zero flag from execute, then releases fetch when the routine ends.
- Sits between fetch, the ucode ROM, decode and execute.

Parameters:
- UPC_W, 5, ghost PC width; ROM depth is 2**UPC_W words.
- LOOP_MAX, 16'hFFFF, max taken ULOOP branches per routine (guard feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trap_valid  in  1  fetch presents a trapped opcode this cycle
- trap_opcode  in  7  trapped opcode
- trap_rd  in  4  destination register of trapped instruction
- trap_rs  in  4  source register of trapped instruction
- trap_imm  in  16  immediate of trapped instruction
- fetch_stall  out  1  freeze architectural PC
- ucode_active  out  1  sequencer busy (state != IDLE)
- ghost_pc  out  UPC_W  ucode ROM address
- rom_instr  in  32  ROM word at ghost_pc (asynchronous read)
- ghost_valid  out  1  ghost_instr valid to decode
- ghost_instr  out  32  substituted ghost instruction
- ghost_ready  in  1  decode accepts ghost_instr
- zflag_valid  in  1  execute reports result of the last ghost compare
- zflag  in  1  zero flag from execute
- ucode_done  out  1  one-cycle pulse when the routine ends
- seq_error  out  1  sticky runaway or abort indication

Behaviour:
- Reset: state=IDLE, ghost_pc=0, iteration count=0, ucode_done=0, seq_error=0. ghost_valid=0 and fetch_stall=0 follow from state. A reset mid-routine aborts immediately with no done pulse.
- Entry table, trap_opcode to ghost_pc:
  - 7'b0010000 -> 0
  - 7'b0011000 -> 8
  - 7'b0110000 -> 16
  - 7'b0111000 -> 24
  - Any other opcode is ignored and the sequencer stays IDLE.
- fetch_stall is combinational: (state!=IDLE) | (trap_valid & opcode in table). Fetch therefore freezes in the trap cycle itself.
- The ROM word class is rom_instr[31:25]:
  - ULOOP = 7'b1110001, target in [UPC_W-1:0]
  - UEND = 7'b1111111
  - anything else is a forwarded op
- Substitution on forwarded ops, applied combinationally to ghost_instr:
  - field [24:21]==4'hF -> trap_rd
  - field [20:17]==4'hE -> trap_rs
  - field [15:0]==16'hFFFF -> trap_imm
  - Trap operands are latched at entry. All other bits pass unchanged.
- States:
  - IDLE: on a valid mapped trap, latch operands, set ghost_pc to the entry address, clear the count, go to ISSUE.
  - ISSUE, forwarded op: ghost_valid=1. On ghost_ready, ghost_pc+1. Without ghost_ready, hold ghost_pc and ghost_instr stable.
  - ISSUE, ULOOP: ghost_valid=0; go to WAITZ.
  - ISSUE, UEND: ghost_valid=0; pulse ucode_done; go to IDLE next cycle. fetch_stall drops in the cycle after the done pulse.
  - WAITZ: ghost_valid=0. On zflag_valid:
    - zflag=0 -> ghost_pc=target, count+1
    - zflag=1 -> ghost_pc+1
    - Either way, return to ISSUE.
- ghost_pc wraps modulo 2**UPC_W if the routine overruns.
- zflag_valid outside WAITZ is ignored.
- trap_valid outside IDLE is ignored; fetch is stalled, so this is legal.
- Simultaneous ghost_ready and a non-forwarded word: ghost_ready is ignored.
- Latency: trap at cycle N -> first ghost_valid at N+1.

Optional Feature:
- Macro UCODE_LOOP_GUARD_EN.
- When defined:
  - A taken ULOOP that would make count exceed LOOP_MAX instead sets seq_error, pulses ucode_done and returns to IDLE.
  - A ghost_pc wrap from the max address back to 0 in ISSUE does the same.
  - seq_error stays set until rst.
- When undefined: no counter logic, no wrap check; seq_error is constant 0.

Test Plan:
- Trap 7'b0010000 with rd=3, rs=5, imm=7. ROM[0]=op with rd=F, rs=E, imm=FFFF. Expect:
  - fetch_stall=1 in the trap cycle
  - ghost_pc=0 and ghost_valid=1 at N+1
  - ghost_instr fields rd=3, rs=5, imm=7
- ghost_ready held low 3 cycles in ISSUE -> ghost_pc and ghost_instr stable. ghost_ready=1 -> ghost_pc 0->1.
- ROM[2]=ULOOP target 1. zflag_valid with zflag=0 twice, then zflag=1:
  - ghost_pc goes 1,2,1,2,1,2,3
  - ghost_valid=0 while in WAITZ
- ROM[3]=UEND -> ucode_done is a single-cycle pulse; fetch_stall=0 the following cycle; state IDLE.
- Trap with opcode 7'b0000001 -> no stall, ghost_valid stays 0. Assert rst mid-WAITZ -> next cycle IDLE, ghost_pc=0, no done pulse.
- With UCODE_LOOP_GUARD_EN and LOOP_MAX=2, zflag always 0 -> seq_error=1 and a done pulse on the 3rd taken loop. seq_error remains set until rst.
